// File: rtl/buzzer_pkg.sv
// Shared types and helpers for the buzzer note player.
package buzzer_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StTone = 2'd1,
    StGap  = 2'd2
  } state_e;

  localparam int unsigned DefHpW  = 16;
  localparam int unsigned DefDurW = 12;

  typedef struct packed {
    logic [DefHpW-1:0]  half_period;
    logic [DefDurW-1:0] ms;
  } note_cmd_t;

  // Clock cycles per millisecond, never below one.
  function automatic int unsigned ms_tick_cycles(input int unsigned clk_hz);
    return (clk_hz / 1000 > 0) ? clk_hz / 1000 : 1;
  endfunction

endpackage

// File: rtl/buzzer_ms_tick.sv
// Millisecond prescaler: counts 0..TICK-1 and flags the last cycle of each period.
module buzzer_ms_tick
  import buzzer_pkg::*;
#(
  parameter int unsigned TICK = 27000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned W = (TICK > 1) ? $clog2(TICK) : 1;
  localparam logic [W-1:0] Last = W'(TICK - 1);

  logic [W-1:0] cnt_q;

  // Prescaler count; clear restarts the period from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i || (cnt_q == Last)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick_o = (cnt_q == Last);

endmodule

// File: rtl/buzzer_note_player.sv
// Note player for a passive buzzer: square wave for note_ms ms, then a GAP_MS silence.
// Optional BUZZER_QUEUE_EN adds a 4-entry command FIFO in front of the player.
module buzzer_note_player
  import buzzer_pkg::*;
#(
  parameter int unsigned CLK_HZ = 27000000,
  parameter int unsigned HP_W   = DefHpW,
  parameter int unsigned DUR_W  = DefDurW,
  parameter int unsigned GAP_MS = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             note_valid_i,
  output logic             note_ready_o,
  input  logic [HP_W-1:0]  note_half_period_i,
  input  logic [DUR_W-1:0] note_ms_i,
  input  logic             abort_i,
  input  logic             mute_n_i,
  output logic             buzz_o,
  output logic             busy_o,
  output logic [1:0]       led_n_o
);

  localparam int unsigned Tick = ms_tick_cycles(CLK_HZ);
  localparam int unsigned GapW = (GAP_MS > 1) ? $clog2(GAP_MS + 1) : 1;
  localparam int unsigned MsW  = (DUR_W > GapW) ? DUR_W : GapW;
  localparam logic [MsW-1:0] GapLast = MsW'(GAP_MS);

  state_e           state_q;
  logic             buzz_q;
  logic [HP_W-1:0]  hp_q;
  logic [DUR_W-1:0] ms_q;
  logic [HP_W-1:0]  tone_cnt_q;
  logic [MsW-1:0]   ms_cnt_q;
  logic [MsW-1:0]   ms_inc;
  logic             tick;
  logic             tone_done;
  logic             presc_clr;
  logic             start;
  logic [HP_W-1:0]  start_hp;
  logic [DUR_W-1:0] start_ms;

`ifdef BUZZER_QUEUE_EN
  typedef struct packed {
    logic [HP_W-1:0]  half_period;
    logic [DUR_W-1:0] ms;
  } cmd_t;

  cmd_t       fifo_q [4];
  logic [1:0] wr_ptr_q;
  logic [1:0] rd_ptr_q;
  logic [2:0] count_q;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;

  assign fifo_full  = (count_q == 3'd4);
  assign fifo_empty = (count_q == 3'd0);
  // Abort wins over a push in the same cycle.
  assign push       = note_valid_i && (!fifo_full || pop) && !abort_i;
  assign pop        = start;
  assign start      = (state_q == StIdle) && !fifo_empty && !abort_i;
  assign start_hp   = fifo_q[rd_ptr_q].half_period;
  assign start_ms   = fifo_q[rd_ptr_q].ms;

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{half_period: note_half_period_i, ms: note_ms_i};
    end
  end

  // FIFO pointers and occupancy; abort flushes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (abort_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  assign note_ready_o = !fifo_full;
  assign busy_o       = (state_q != StIdle) || !fifo_empty;
`else
  assign start        = (state_q == StIdle) && note_valid_i && !abort_i;
  assign start_hp     = note_half_period_i;
  assign start_ms     = note_ms_i;
  assign note_ready_o = (state_q == StIdle);
  assign busy_o       = (state_q != StIdle);
`endif

  assign ms_inc    = ms_cnt_q + 1'b1;
  assign tone_done = (state_q == StTone) && tick && (ms_inc == MsW'(ms_q));

  // Prescaler restarts at every TONE or GAP entry and is parked while idle.
  always_comb begin
    presc_clr = abort_i || (state_q == StIdle) || tone_done;
  end

  buzzer_ms_tick #(
    .TICK (Tick)
  ) u_ms_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (presc_clr),
    .tick_o (tick)
  );

  // Player FSM: accept, tone generation with ms timing, then silence gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      buzz_q     <= 1'b0;
      hp_q       <= '0;
      ms_q       <= '0;
      tone_cnt_q <= '0;
      ms_cnt_q   <= '0;
    end else if (abort_i) begin
      state_q    <= StIdle;
      buzz_q     <= 1'b0;
      tone_cnt_q <= '0;
      ms_cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            hp_q       <= start_hp;
            ms_q       <= start_ms;
            tone_cnt_q <= '0;
            ms_cnt_q   <= '0;
            buzz_q     <= 1'b0;
            state_q    <= (start_ms == '0) ? StGap : StTone;
          end
        end
        StTone: begin
          // hp == 0 is a rest: timing runs, the toggle register stays low.
          if (hp_q != '0) begin
            if (tone_cnt_q == hp_q - 1'b1) begin
              tone_cnt_q <= '0;
              buzz_q     <= ~buzz_q;
            end else begin
              tone_cnt_q <= tone_cnt_q + 1'b1;
            end
          end
          if (tick) begin
            if (tone_done) begin
              state_q    <= StGap;
              buzz_q     <= 1'b0;
              tone_cnt_q <= '0;
              ms_cnt_q   <= '0;
            end else begin
              ms_cnt_q <= ms_inc;
            end
          end
        end
        StGap: begin
          if (GAP_MS == 0) begin
            state_q <= StIdle;
          end else if (tick) begin
            if (ms_inc == GapLast) begin
              state_q  <= StIdle;
              ms_cnt_q <= '0;
            end else begin
              ms_cnt_q <= ms_inc;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Mute only gates the pin so the internal waveform keeps its phase.
  assign buzz_o  = buzz_q & mute_n_i;
  assign led_n_o = {~buzz_o, ~busy_o};

endmodule

// File: tb/tb_buzzer_note_player.sv
// Directed bench for buzzer_note_player at CLK_HZ=10000 (10-cycle ms), GAP_MS=2.
module tb_buzzer_note_player;

`ifdef BUZZER_QUEUE_EN
  localparam bit QueueEn = 1'b1;
`else
  localparam bit QueueEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        note_valid = 1'b0;
  logic        note_ready;
  logic [15:0] hp = '0;
  logic [11:0] ms = '0;
  logic        abort = 1'b0;
  logic        mute_n = 1'b1;
  logic        buzz;
  logic        busy;
  logic [1:0]  led_n;

  int vectors = 0;
  int miscompares = 0;

  buzzer_note_player #(
    .CLK_HZ (10000),
    .HP_W   (16),
    .DUR_W  (12),
    .GAP_MS (2)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .note_valid_i       (note_valid),
    .note_ready_o       (note_ready),
    .note_half_period_i (hp),
    .note_ms_i          (ms),
    .abort_i            (abort),
    .mute_n_i           (mute_n),
    .buzz_o             (buzz),
    .busy_o             (busy),
    .led_n_o            (led_n)
  );

  always #5 clk = ~clk;

  // Present one command; returns so that the next negedge samples the first player cycle.
  task automatic send(input logic [15:0] h, input logic [11:0] m);
    int t = 0;
    while (note_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      vectors++;
      miscompares++;
      $display("FAIL send_ready: note_ready=%b required 1", note_ready);
    end
    note_valid = 1'b1;
    hp = h;
    ms = m;
    @(posedge clk);
    #1 note_valid = 1'b0;
    if (QueueEn) @(negedge clk);
  endtask

  task automatic test_reset;
    #3;
    vectors++; if (buzz !== 1'b0) begin miscompares++; $display("FAIL reset_buzz: got %b want 0", buzz); end
    vectors++; if (note_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", note_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (led_n !== 2'b11) begin miscompares++; $display("FAIL reset_led: got %b want 11", led_n); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL post_reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_tone;
    logic eb;
    send(16'd3, 12'd2);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      eb = (k < 20) && ((k / 3) % 2 == 1);
      vectors++; if (buzz !== eb) begin miscompares++; $display("FAIL tone_buzz k=%0d: got %b want %b", k, buzz, eb); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL tone_busy k=%0d: got %b want 1", k, busy); end
      vectors++; if (note_ready !== QueueEn) begin miscompares++; $display("FAIL tone_ready k=%0d: got %b want %b", k, note_ready, QueueEn); end
    end
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL tone_end_busy: got %b want 0", busy); end
    vectors++; if (note_ready !== 1'b1) begin miscompares++; $display("FAIL tone_end_ready: got %b want 1", note_ready); end
    vectors++; if (led_n !== 2'b11) begin miscompares++; $display("FAIL tone_end_led: got %b want 11", led_n); end
  endtask

  task automatic test_rest;
    send(16'd0, 12'd1);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      vectors++; if (buzz !== 1'b0) begin miscompares++; $display("FAIL rest_buzz k=%0d: got %b want 0", k, buzz); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rest_busy k=%0d: got %b want 1", k, busy); end
    end
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rest_end_busy: got %b want 0", busy); end
  endtask

  task automatic test_zero_ms;
    send(16'd4, 12'd0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      vectors++; if (buzz !== 1'b0) begin miscompares++; $display("FAIL zero_ms_buzz k=%0d: got %b want 0", k, buzz); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL zero_ms_busy k=%0d: got %b want 1", k, busy); end
    end
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL zero_ms_end_busy: got %b want 0", busy); end
  endtask

  task automatic test_mute;
    logic eb;
    logic muted;
    send(16'd5, 12'd3);
    for (int k = 0; k < 50; k++) begin
      muted = (k >= 8) && (k < 15);
      mute_n = ~muted;
      @(negedge clk);
      eb = (k < 30) && ((k / 5) % 2 == 1) && !muted;
      vectors++; if (buzz !== eb) begin miscompares++; $display("FAIL mute_buzz k=%0d: got %b want %b", k, buzz, eb); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mute_busy k=%0d: got %b want 1", k, busy); end
    end
    mute_n = 1'b1;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mute_end_busy: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    logic eb;
    send(16'd2, 12'd1);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      eb = (k < 10) && ((k / 2) % 2 == 1);
      vectors++; if (buzz !== eb) begin miscompares++; $display("FAIL b2b_first_buzz k=%0d: got %b want %b", k, buzz, eb); end
    end
    @(negedge clk);
    vectors++; if (note_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_idle_ready: got %b want 1", note_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_busy: got %b want 0", busy); end
    send(16'd1, 12'd1);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      eb = (k < 10) && (k % 2 == 1);
      vectors++; if (buzz !== eb) begin miscompares++; $display("FAIL b2b_second_buzz k=%0d: got %b want %b", k, buzz, eb); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_second_busy k=%0d: got %b want 1", k, busy); end
    end
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_end_busy: got %b want 0", busy); end
  endtask

  task automatic test_abort;
    send(16'd2, 12'd3);
    repeat (6) @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL abort_pre_busy: got %b want 1", busy); end
    @(posedge clk);
    #1;
    abort = 1'b1;
    note_valid = 1'b1;
    hp = 16'd7;
    ms = 12'd1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    note_valid = 1'b0;
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b want 0", busy); end
    vectors++; if (buzz !== 1'b0) begin miscompares++; $display("FAIL abort_buzz: got %b want 0", buzz); end
    vectors++; if (note_ready !== 1'b1) begin miscompares++; $display("FAIL abort_ready: got %b want 1", note_ready); end
    vectors++; if (led_n !== 2'b11) begin miscompares++; $display("FAIL abort_led: got %b want 11", led_n); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_not_accepted k=%0d: got %b want 0", k, busy); end
    end
    // Abort in IDLE beats a simultaneous command.
    @(posedge clk);
    #1;
    abort = 1'b1;
    note_valid = 1'b1;
    hp = 16'd4;
    ms = 12'd1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    note_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_idle k=%0d: got %b want 0", k, busy); end
    end
  endtask

  task automatic test_reset_mid;
    send(16'd3, 12'd2);
    repeat (5) @(negedge clk);
    vectors++; if (buzz !== 1'b1) begin miscompares++; $display("FAIL rmid_pre_buzz: got %b want 1", buzz); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (buzz !== 1'b0) begin miscompares++; $display("FAIL rmid_buzz: got %b want 0", buzz); end
    vectors++; if (note_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_ready: got %b want 1", note_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy: got %b want 0", busy); end
    vectors++; if (led_n !== 2'b11) begin miscompares++; $display("FAIL rmid_led: got %b want 11", led_n); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rmid_after_busy: got %b want 0", busy); end
  endtask

`ifdef BUZZER_QUEUE_EN
  task automatic test_queue_abort;
    @(posedge clk);
    #1;
    note_valid = 1'b1;
    hp = 16'd5;
    ms = 12'd3;
    repeat (5) @(posedge clk);
    #1 note_valid = 1'b0;
    @(negedge clk);
    vectors++; if (note_ready !== 1'b0) begin miscompares++; $display("FAIL queue_full_ready: got %b want 0", note_ready); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL queue_full_busy: got %b want 1", busy); end
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL queue_flush_busy k=%0d: got %b want 0", k, busy); end
      vectors++; if (note_ready !== 1'b1) begin miscompares++; $display("FAIL queue_flush_ready k=%0d: got %b want 1", k, note_ready); end
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_tone();
    test_rest();
    test_zero_ms();
    test_mute();
    test_back_to_back();
    test_abort();
    test_reset_mid();
`ifdef BUZZER_QUEUE_EN
    test_queue_abort();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
